// File: rtl/seg7_disp_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_disp_sched_if
//  Description : Bundle for the display scheduler.
//                - Two value sources (A, B) with a req/ack capture handshake.
//                - The operand/result pair of the external bin_to_bcd
//                  converter.
//                - The common-anode display drive and the current owner.
//                The slave modport is the scheduler's view. The master
//                modport is the environment's view: value sources, converter
//                and display.
//  Signals     : req_a/val_a/ack_a   source A handshake and 12-bit value
//                req_b/val_b/ack_b   source B handshake and 12-bit value
//                cnv_bin             operand driven to bin_to_bcd
//                cnv_ones/tens/hund  BCD digits returned by bin_to_bcd
//                an                  active-low digit enables, an[0] rightmost
//                seg                 active-low segments {g,f,e,d,c,b,a}
//                owner               current display owner, 0 = A, 1 = B
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_disp_sched_if;
  logic        req_a;
  logic [11:0] val_a;
  logic        ack_a;
  logic        req_b;
  logic [11:0] val_b;
  logic        ack_b;
  logic [11:0] cnv_bin;
  logic [3:0]  cnv_ones;
  logic [3:0]  cnv_tens;
  logic [3:0]  cnv_hund;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        owner;

  modport master (
    output req_a, val_a, req_b, val_b, cnv_ones, cnv_tens, cnv_hund,
    input  ack_a, ack_b, cnv_bin, an, seg, owner
  );

  modport slave (
    input  req_a, val_a, req_b, val_b, cnv_ones, cnv_tens, cnv_hund,
    output ack_a, ack_b, cnv_bin, an, seg, owner
  );
endinterface
`default_nettype wire

// File: rtl/seg7_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_disp_sched
//  Description : Time-shares one external bin_to_bcd converter and one
//                4-digit common-anode display between two value sources.
//                It also does digit multiplexing, leading-zero blanking,
//                overflow dashes and the source-letter digit. Every frame
//                reloads the owner's latest value. Ownership is
//                re-arbitrated every HOLD_SCANS frames.
//  Parameters  : REFRESH_DIV  clk cycles each digit stays enabled (>= 2)
//                HOLD_SCANS   frames per ownership period (>= 1)
//  Ports       : clk          rising-edge clock
//                rst_n        asynchronous active-low reset
//                bus          seg7_disp_sched_if.slave (handshakes, converter,
//                             display, owner)
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_disp_sched #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_SCANS  = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_disp_sched_if.slave   bus
);

  localparam int c_CNT_W = $clog2(REFRESH_DIV);
  localparam int c_FRM_W = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;

  localparam logic [c_CNT_W-1:0] c_REF_LAST = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(HOLD_SCANS - 1);
  localparam logic [c_FRM_W-1:0] c_FRM_ONE  = c_FRM_W'(1);

  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
  localparam logic [6:0] c_SEG_A     = 7'b0001000;
  localparam logic [6:0] c_SEG_B     = 7'b0000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LATCH = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Capture side
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_vld_a;
  logic        r_vld_b;
  logic [11:0] r_reg_a;
  logic [11:0] r_reg_b;

  // Display side
  logic               r_owner;
  logic [11:0]        r_cnv_bin;
  logic               r_ofl;
  logic [3:0]         r_hund;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [c_FRM_W-1:0] r_frame;

  logic        w_cnt_wrap;
  logic        w_frame_end;
  logic        w_any_vld;
  logic        w_other_vld;
  logic [11:0] w_owner_val;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;

  function automatic logic [6:0] f_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = c_SEG_BLANK;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Capture. The ack register also gates the next capture, so a held req
  // yields an ack every other cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_vld_a <= 1'b0;
      r_vld_b <= 1'b0;
      r_reg_a <= 12'd0;
      r_reg_b <= 12'd0;
    end else begin
      r_ack_a <= bus.req_a & ~r_ack_a;
      r_ack_b <= bus.req_b & ~r_ack_b;
      if (bus.req_a && !r_ack_a) begin
        r_reg_a <= bus.val_a;
        r_vld_a <= 1'b1;
      end
      if (bus.req_b && !r_ack_b) begin
        r_reg_b <= bus.val_b;
        r_vld_b <= 1'b1;
      end
    end
  end

  assign w_any_vld   = r_vld_a | r_vld_b;
  assign w_owner_val = r_owner ? r_reg_b : r_reg_a;
  assign w_other_vld = r_owner ? r_vld_a : r_vld_b;
  assign w_cnt_wrap  = (r_cnt == c_REF_LAST);
  assign w_frame_end = w_cnt_wrap && (r_idx == 2'd3);

  // --------------------------------------------------------------------------
  // FSM state register and next-state logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_vld) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_SCAN;
      ST_SCAN:  if (w_frame_end) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: converter operand, digit latches, refresh/digit/frame counters
  // and ownership.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_cnv_bin <= 12'd0;
      r_ofl     <= 1'b0;
      r_hund    <= 4'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_frame   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A wins when both sources are already valid.
          if (w_any_vld) r_owner <= ~r_vld_a;
        end
        ST_LOAD: begin
          // Reads the pre-capture value. A capture on this same edge is
          // picked up by the next frame.
          r_cnv_bin <= w_owner_val;
          r_ofl     <= (w_owner_val > 12'd999);
        end
        ST_LATCH: begin
          // cnv_bin has been stable for the whole LATCH cycle.
          r_hund <= bus.cnv_hund;
          r_tens <= bus.cnv_tens;
          r_ones <= bus.cnv_ones;
          r_cnt  <= '0;
          r_idx  <= 2'd0;
        end
        ST_SCAN: begin
          if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (r_frame == c_FRM_LAST) begin
                r_frame <= '0;
                if (w_other_vld) r_owner <= ~r_owner;
              end else begin
                r_frame <= r_frame + c_FRM_ONE;
              end
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Digit drive. Anodes are dark outside SCAN, which also keeps LOAD/LATCH
  // from ghosting the previous frame's digits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_an  = 4'b1111;
    w_seg = c_SEG_BLANK;
    if (r_state == ST_SCAN) begin
      case (r_idx)
        2'd0: begin
          w_an  = 4'b1110;
          w_seg = r_ofl ? c_SEG_DASH : f_dec(r_ones);
        end
        2'd1: begin
          w_an = 4'b1101;
          if (r_ofl)                                w_seg = c_SEG_DASH;
          else if (r_hund == 4'd0 && r_tens == 4'd0) w_seg = c_SEG_BLANK;
          else                                      w_seg = f_dec(r_tens);
        end
        2'd2: begin
          w_an = 4'b1011;
          if (r_ofl)               w_seg = c_SEG_DASH;
          else if (r_hund == 4'd0) w_seg = c_SEG_BLANK;
          else                     w_seg = f_dec(r_hund);
        end
        default: begin
          w_an  = 4'b0111;
          w_seg = r_owner ? c_SEG_B : c_SEG_A;
        end
      endcase
    end
  end

  assign bus.ack_a   = r_ack_a;
  assign bus.ack_b   = r_ack_b;
  assign bus.cnv_bin = r_cnv_bin;
  assign bus.an      = w_an;
  assign bus.seg     = w_seg;
  assign bus.owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_seg7_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_disp_sched
//  Description : Self-checking bench for seg7_disp_sched.
//                - Models the external bin_to_bcd converter.
//                - Runs directed and random source traffic.
//                - A frame-position reference model predicts ack, owner,
//                  cnv_bin, an and seg on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_disp_sched;

  localparam int R     = 4;
  localparam int H     = 2;
  localparam int FRAME = 4 * R + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg7_disp_sched_if bus ();

  seg7_disp_sched #(
    .REFRESH_DIV (R),
    .HOLD_SCANS  (H)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External combinational bin_to_bcd
  always_comb begin
    bus.cnv_ones = 4'(bus.cnv_bin % 12'd10);
    bus.cnv_tens = 4'((bus.cnv_bin / 12'd10) % 12'd10);
    bus.cnv_hund = 4'((bus.cnv_bin / 12'd100) % 12'd10);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Reference model. m_pos is the cycle position inside a frame:
  // 0 = LOAD, 1 = LATCH, 2..FRAME-1 = scan cycles.
  int m_reg [2];
  int m_vld [2];
  int m_ack [2];
  int m_owner, m_started, m_pos, m_loaded, m_shown, m_frames;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_reg[i] = 0; m_vld[i] = 0; m_ack[i] = 0;
    end
    m_owner = 0; m_started = 0; m_pos = 0;
    m_loaded = 0; m_shown = 0; m_frames = 0;
  endfunction

  // Called right after a rising edge. Inputs still hold their pre-edge values.
  function automatic void model_edge();
    int req [2];
    int val [2];
    if (!rst_n) begin
      model_reset();
    end else begin
      req[0] = int'(bus.req_a); val[0] = int'(bus.val_a);
      req[1] = int'(bus.req_b); val[1] = int'(bus.val_b);
      if (m_started == 0) begin
        if (m_vld[0] != 0 || m_vld[1] != 0) begin
          m_started = 1;
          m_owner   = (m_vld[0] != 0) ? 0 : 1;
          m_pos     = 0;
        end
      end else if (m_pos == 0) begin
        m_loaded = m_reg[m_owner];
        m_pos    = 1;
      end else if (m_pos == 1) begin
        m_shown = m_loaded;
        m_pos   = 2;
      end else if (m_pos == FRAME - 1) begin
        m_frames++;
        if (m_frames == H) begin
          m_frames = 0;
          if (m_vld[1 - m_owner] != 0) m_owner = 1 - m_owner;
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
      for (int x = 0; x < 2; x++) begin
        if (req[x] != 0 && m_ack[x] == 0) begin
          m_reg[x] = val[x]; m_vld[x] = 1; m_ack[x] = 1;
        end else begin
          m_ack[x] = 0;
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_an();
    int d;
    if (m_started == 0 || m_pos < 2) return 4'hF;
    d = (m_pos - 2) / R;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [6:0] exp_seg();
    int d, h, t, o;
    if (m_started == 0 || m_pos < 2) return 7'h7F;
    d = (m_pos - 2) / R;
    if (d == 3) return (m_owner != 0) ? 7'b0000011 : 7'b0001000;
    if (m_shown > 999) return 7'b0111111;
    h = m_shown / 100; t = (m_shown / 10) % 10; o = m_shown % 10;
    if (d == 0) return seg_tab[o];
    if (d == 1) return (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
    return (h == 0) ? 7'h7F : seg_tab[h];
  endfunction

  task automatic compare_all();
    chk("ack_a",   bus.ack_a,   m_ack[0]);
    chk("ack_b",   bus.ack_b,   m_ack[1]);
    chk("owner",   bus.owner,   m_owner);
    chk("cnv_bin", bus.cnv_bin, m_loaded);
    chk("an",      bus.an,      exp_an());
    chk("seg",     bus.seg,     exp_seg());
  endtask

  logic hold_a  = 1'b0;
  logic rand_en = 1'b0;

  function automatic logic [11:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 12'($urandom_range(0, 9));
      1:       return 12'($urandom_range(0, 99));
      2:       return 12'($urandom_range(990, 1010));
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic drive_next();
    if (bus.req_a && bus.ack_a && !hold_a) bus.req_a = 1'b0;
    if (bus.req_b && bus.ack_b) bus.req_b = 1'b0;
    if (rand_en) begin
      if (!bus.req_a && $urandom_range(0, 15) == 0) begin
        bus.req_a = 1'b1; bus.val_a = rand_val();
      end
      if (!bus.req_b && $urandom_range(0, 15) == 0) begin
        bus.req_b = 1'b1; bus.val_b = rand_val();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    drive_next();
  endtask

  task automatic post_a(input logic [11:0] v);
    int n = 0;
    while (bus.req_a && n < 10) begin step(); n++; end
    bus.req_a = 1'b1;
    bus.val_a = v;
    step();
  endtask

  // Reset asserted between edges; outputs must drop immediately.
  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an",    bus.an,    4'hF);
    chk("rst_seg",   bus.seg,   7'h7F);
    chk("rst_owner", bus.owner, 1'b0);
    chk("rst_ack_a", bus.ack_a, 1'b0);
    chk("rst_ack_b", bus.ack_b, 1'b0);
    chk("rst_cnv",   bus.cnv_bin, 12'd0);
    model_reset();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    hold_a    = 1'b0;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] pat;
    logic [4:0] pat_exp;
    int n;
    bus.req_a = 1'b0; bus.val_a = 12'd0;
    bus.req_b = 1'b0; bus.val_b = 12'd0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Idle with no requests
    repeat (20) step();
    chk("idle_an", bus.an, 4'hF);

    // Single source A = 305
    bus.req_a = 1'b1; bus.val_a = 12'd305;
    step();
    chk("ack_a_lat", bus.ack_a, 1'b1);
    repeat (4 * FRAME) step();
    chk("cnv_305", bus.cnv_bin, 12'd305);

    // Blanking and overflow
    post_a(12'd7);
    repeat (2 * FRAME) step();
    post_a(12'd1000);
    repeat (2 * FRAME) step();

    // Round-robin with simultaneous requests after a mid-frame reset
    do_reset();
    bus.req_a = 1'b1; bus.val_a = 12'd12;
    bus.req_b = 1'b1; bus.val_b = 12'd999;
    step();
    chk("rr_ack_a", bus.ack_a, 1'b1);
    chk("rr_ack_b", bus.ack_b, 1'b1);
    repeat (5 * FRAME) step();

    // Update mid-frame: post 43 while idx1 of a frame showing 42
    post_a(12'd42);
    n = 0;
    while (!(m_started != 0 && m_pos >= 2 + R && m_pos < 2 + 2 * R && m_shown == 42)
           && n < 300) begin
      step();
      n++;
    end
    chk("wait_idx1", (n < 300), 1'b1);
    post_a(12'd43);
    repeat (3 * FRAME) step();

    // Back-to-back requests
    do_reset();
    hold_a = 1'b1;
    bus.req_a = 1'b1; bus.val_a = 12'd100;
    pat[0] = bus.ack_a;
    for (int i = 1; i < 5; i++) begin
      step();
      pat[i] = bus.ack_a;
    end
    hold_a    = 1'b0;
    bus.req_a = 1'b0;
    pat_exp   = 5'b01010;
    chk("b2b_ack_pat", pat, pat_exp);
    repeat (2 * FRAME) step();

    // Random traffic, with one reset in the middle
    rand_en = 1'b1;
    repeat (1500) step();
    do_reset();
    repeat (1500) step();
    rand_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_disp_sched.md
# seg7_disp_sched

Display scheduler for the 7-segment front end. Two value sources (A, B) post 12-bit binary values. The block time-shares the external combinational `bin_to_bcd` converter and one 4-digit common-anode display between them. It also owns digit multiplexing, leading-zero blanking, overflow indication and the source-letter digit.

## Interface
- `REFRESH_DIV`, 50000: clk cycles each digit stays enabled; legal range ≥ 2.
- `HOLD_SCANS`, 256: full 4-digit frames one source owns the display before ownership is re-arbitrated; legal range ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_a` input 1: source A value-valid; level, held until `ack_a`.
- `val_a` input 12: source A binary value.
- `ack_a` output 1: one-cycle pulse; `val_a` captured.
- `req_b` input 1: source B value-valid.
- `val_b` input 12: source B binary value.
- `ack_b` output 1: one-cycle pulse; `val_b` captured.
- `cnv_bin` output 12: registered operand driven to the external `bin_to_bcd`.
- `cnv_ones` input 4: converter ones digit.
- `cnv_tens` input 4: converter tens digit.
- `cnv_hund` input 4: converter hundreds digit.
- `an` output 4: digit enables, active-low; `an[0]` is the rightmost digit.
- `seg` output 7: segments, active-low, bit order `{g,f,e,d,c,b,a}`.
- `owner` output 1: current display owner; 0 = A, 1 = B.

## Operation
- **Capture:**
  - `req_x` high with `ack_x` low → `reg_x <= val_x`, `vld_x <= 1`, `ack_x` = 1 next cycle.
  - `ack_x` is never high on two consecutive cycles.
  - A and B are captured independently, and can be captured in the same cycle.
- **FSM states** are IDLE, LOAD, LATCH and SCAN.
  - IDLE: `an = 4'b1111`. Moves to LOAD once `vld_a|vld_b`. Owner is set to the valid source; A wins if both are valid.
  - LOAD: one cycle. `cnv_bin <= reg_owner`, and the overflow flag `ofl <= (reg_owner > 999)`.
  - LATCH: one cycle. Latches `cnv_hund/tens/ones` into the display registers, then goes to SCAN with the refresh counter cleared and digit index 0.
  - SCAN: the refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments mod 4.
    - On wrap with index 3, the frame counter increments.
    - Re-arbitration happens at that same wrap, when the frame counter reaches HOLD_SCANS. If the other source's `vld` is set, owner toggles. The frame counter clears either way.
    - Every index-3 wrap goes to LOAD, so each frame shows the latest captured value of its owner.
- **Digit content**, with one digit enabled per cycle in SCAN:
  - idx0: ones.
  - idx1: tens; blank if hundreds = 0 and tens = 0.
  - idx2: hundreds; blank if 0.
  - idx3: source letter, 'A' = 7'b0001000 or 'b' = 7'b0000011.
  - If `ofl`, idx0–2 all show '-' = 7'b0111111.
  - Digits 0–9 use the standard active-low codes, e.g. 0 = 7'b1000000. Blank is 7'b1111111.
- During LOAD and LATCH, `an = 4'b1111`. Anodes are blanked for these 2 cycles per frame to avoid ghosting.

## Timing
- **Reset values:**
  - Outputs: `an = 4'hF`, `seg = 7'h7F`, `ack_a = ack_b = 0`, `cnv_bin = 0`, `owner = 0`.
  - Internal: `vld_a = vld_b = 0`, all counters 0, state IDLE.
- Reset mid-frame immediately returns to these values. It takes effect asynchronously; release is synchronous.
- **Capture-to-display latency:**
  - `req` → `ack` is 1 cycle.
  - A value captured before an index-3 wrap is shown in the frame starting 2 cycles after that wrap.
  - Worst case ≈ 4·REFRESH_DIV + 3 cycles.
- First value after reset: IDLE→LOAD takes 1 cycle after `vld` sets, LOAD→LATCH 1 cycle, and `an[0]` goes low on the cycle after LATCH.
- Frame length is 4·REFRESH_DIV + 2 cycles.
- `cnv_bin` is stable for at least 1 full cycle before LATCH samples the converter outputs.
- A capture in the same cycle as LOAD does not affect that LOAD; LOAD reads the pre-capture `reg_x`.

## Test plan
REFRESH_DIV=4 and HOLD_SCANS=2 apply throughout.

- **Reset state:** reset asserted mid-SCAN → next edge shows `an = F`, `seg = 7F`, `owner = 0`, no acks. After release with no `req`, the block stays in IDLE indefinitely.
- **Single source A:** `val_a = 305`, `req_a` high → `ack_a` pulse 1 cycle later, `cnv_bin = 305`.
  - Scan shows idx0 '5' (0010010), idx1 '0', idx2 '3', idx3 'A'.
  - `owner` stays 0 forever, since B is never valid.
- **Blanking and overflow:**
  - `val_a = 7` → idx1 and idx2 are 7'h7F.
  - `val_a = 1000` → idx0–2 are 0111111 and idx3 is 'A'.
- **Round-robin:** `val_a = 12` and `val_b = 999` requested in the same cycle → both acks in the same cycle.
  - A is shown first.
  - After 2 frames, `owner` → 1 and the display shows 999 with 'b'.
  - After 2 more frames, `owner` returns to 0.
- **Update mid-frame:** `val_a` changes 42→43 during idx1 of a frame → the current frame still shows 42, and the next frame shows 43. `an` is F for exactly 2 cycles between the frames.
- **Back-to-back req:** `req_a` held high for 5 cycles → `ack_a` pattern is 0,1,0,1,0; never two consecutive acks.
